// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues sequential fetch requests, buffers in-order responses, and flushes on redirect.
// Optional IFU_MISALIGN_EN adds a fetch_misalign flag that stalls fetch after a misaligned redirect.
module ifu_prefetch #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(64'h80000000)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef IFU_MISALIGN_EN
  ,
  output logic                  fetch_misalign
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic [ADDR_WIDTH-1:0]   rsp_pc;
  logic [ADDR_WIDTH-1:0]   pc_mem [DEPTH];
  logic [INST_WIDTH-1:0]   inst_mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        outstanding;
  logic [CNT_W-1:0]        drop_cnt;
  logic [CNT_W-1:0]        drop_on_redirect;
  logic [ADDR_WIDTH-1:0]   redirect_aligned;
  logic                    credit_ok;
  logic                    req_fire;
  logic                    push;
  logic                    pop;
  logic                    halt;

  assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign credit_ok        = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
  // A response landing in the redirect cycle is already dropped, so it leaves the stale count.
  assign drop_on_redirect = outstanding - CNT_W'(imem_rsp_valid);

  assign req_fire      = imem_req_valid & imem_req_ready;
  assign imem_req_addr = fetch_pc;
  assign out_valid     = (count != '0) && !halt;
  assign pop           = out_valid & out_ready;
  assign out_pc        = pc_mem[rd_ptr];
  assign out_inst      = inst_mem[rd_ptr];

`ifdef IFU_MISALIGN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_misalign <= 1'b0;
    end else if (redirect_valid) begin
      fetch_misalign <= |redirect_pc[1:0];
    end
  end
  assign halt = fetch_misalign;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = (drop_on_redirect != '0) ? FLUSH : FETCH;
    end else if (state == FLUSH && imem_rsp_valid && drop_cnt == CNT_W'(1)) begin
      state_nxt = FETCH;
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    push           = 1'b0;
    if (!rst && !redirect_valid && state == FETCH) begin
      imem_req_valid = credit_ok && !halt;
      push           = imem_rsp_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        drop_cnt <= drop_on_redirect;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
        if (state == FLUSH && imem_rsp_valid) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
      end
    end
  end

  // Buffer storage holds data only; occupancy is tracked by the reset control above.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      inst_mem[wr_ptr] <= imem_rsp_inst;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: memory model with configurable latency, output scoreboard, redirect vector table.
// Build with IFU_MISALIGN_EN defined to exercise fetch_misalign.
module tb_ifu_prefetch;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef IFU_MISALIGN_EN
  logic        fetch_misalign;
`endif

  ifu_prefetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_inst(imem_rsp_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_MISALIGN_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [63:0] rpc; logic [63:0] first; logic [63:0] second; bit mis; } vec_t;

  mreq_t mem_q[$];
  exp_t  exp_q[$];
  vec_t  tbl[6];

  int          lat;
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          n_req;
  int          n_out;
  logic [63:0] exp_fetch_pc;
  logic        obs_req_valid, obs_req_fire, obs_out_valid, obs_out_fire, obs_rsp_valid;
  logic [63:0] obs_req_addr, obs_out_pc;
  bit          got;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // One clock cycle: drive memory response, observe, update models, advance past the edge.
  task automatic step();
    exp_t e;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_inst  = inst_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_inst  = '0;
    end
    #1;
    obs_req_valid = imem_req_valid;
    obs_req_addr  = imem_req_addr;
    obs_req_fire  = !rst && imem_req_valid && imem_req_ready;
    obs_out_valid = out_valid;
    obs_out_pc    = out_pc;
    obs_out_fire  = !rst && out_valid && out_ready;
    obs_rsp_valid = imem_rsp_valid;
    if (obs_req_fire) begin
      check("req_addr", imem_req_addr, exp_fetch_pc);
      mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_q.push_back('{pc: imem_req_addr, inst: inst_of(imem_req_addr)});
      exp_fetch_pc += 64'd4;
      n_req++;
    end
    if (obs_out_fire) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("out_spurious", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_inst", {32'd0, out_inst}, {32'd0, e.inst});
      end
    end
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (redirect_valid && !rst) begin
      check("req_on_redirect", {63'd0, imem_req_valid}, 64'd0);
      exp_q.delete();
      exp_fetch_pc = redirect_pc & ~64'h3;
    end
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      exp_fetch_pc = RPC;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    check("rst_req_valid", {63'd0, obs_req_valid}, 64'd0);
    rst = 1'b0;
    n_req = 0;
    n_out = 0;
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{rpc: 64'h0000_0000_8000_1000, first: 64'h0000_0000_8000_1000, second: 64'h0000_0000_8000_1004, mis: 1'b0};
    tbl[1] = '{rpc: 64'h0000_0000_8000_0006, first: 64'h0000_0000_8000_0004, second: 64'h0000_0000_8000_0008, mis: 1'b1};
    tbl[2] = '{rpc: 64'h0000_0000_8000_000B, first: 64'h0000_0000_8000_0008, second: 64'h0000_0000_8000_000C, mis: 1'b1};
    tbl[3] = '{rpc: 64'hFFFF_FFFF_FFFF_FFFC, first: 64'hFFFF_FFFF_FFFF_FFFC, second: 64'h0, mis: 1'b0};
    tbl[4] = '{rpc: 64'hFFFF_FFFF_FFFF_FFFF, first: 64'hFFFF_FFFF_FFFF_FFFC, second: 64'h0, mis: 1'b1};
    tbl[5] = '{rpc: 64'h0000_0000_0000_0010, first: 64'h0000_0000_0000_0010, second: 64'h0000_0000_0000_0014, mis: 1'b0};

    n_checks = 0; n_pass = 0; n_req = 0; n_out = 0; cyc = 0; lat = 1;
    exp_fetch_pc = RPC;
    rst = 1'b1; imem_req_ready = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_inst = '0;
    @(posedge clk);
    #1;

    // Reset and streaming with a 1-cycle memory.
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    step();
    check("c1_out_valid", {63'd0, obs_out_valid}, 64'd0);
    check("c1_req_valid", {63'd0, obs_req_valid}, 64'd1);
    check("c1_req_addr", obs_req_addr, RPC);
`ifdef IFU_MISALIGN_EN
    check("rst_misalign", {63'd0, fetch_misalign}, 64'd0);
`endif
    step();
    check("c2_out_valid", {63'd0, obs_out_valid}, 64'd0);
    check("c2_req_addr", obs_req_addr, RPC + 64'd4);
    step();
    check("c3_out_valid", {63'd0, obs_out_valid}, 64'd1);
    check("c3_out_pc", obs_out_pc, RPC);
    repeat (20) step();
    check("stream_out_count", {63'd0, n_out >= 20}, 64'd1);

    // Backpressure: fetch stops once the buffer plus in-flight requests fill DEPTH.
    out_ready = 1'b0;
    do_reset();
    repeat (12) step();
    check("bp_req_count", 64'(n_req), 64'd4);
    check("bp_req_valid", {63'd0, obs_req_valid}, 64'd0);
    check("bp_out_valid", {63'd0, obs_out_valid}, 64'd1);
    out_ready = 1'b1;
    repeat (8) step();
    check("bp_drained", {63'd0, n_out >= 4}, 64'd1);
    check("bp_resumed", {63'd0, n_req > 4}, 64'd1);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    step();
    step();
    imem_req_ready = 1'b0;
    redirect_to(64'h8000_1000);
    imem_req_ready = 1'b1;
    step();
    check("fl1_rsp", {63'd0, obs_rsp_valid}, 64'd1);
    check("fl1_req_valid", {63'd0, obs_req_valid}, 64'd0);
    check("fl1_out_valid", {63'd0, obs_out_valid}, 64'd0);
    step();
    check("fl2_rsp", {63'd0, obs_rsp_valid}, 64'd1);
    check("fl2_req_valid", {63'd0, obs_req_valid}, 64'd0);
    check("fl2_out_valid", {63'd0, obs_out_valid}, 64'd0);
    step();
    check("post_flush_req_valid", {63'd0, obs_req_valid}, 64'd1);
    check("post_flush_req_addr", obs_req_addr, 64'h8000_1000);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      got = obs_out_fire;
    end
    check("post_flush_out_seen", {63'd0, got}, 64'd1);
    check("post_flush_out_pc", obs_out_pc, 64'h8000_1000);

    // Redirect coinciding with a response and an output handshake.
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
    do_reset();
    repeat (3) step();
    out_ready = 1'b1;
    redirect_to(64'h8000_2000);
    check("sim_rsp", {63'd0, obs_rsp_valid}, 64'd1);
    check("sim_out_fire", {63'd0, obs_out_fire}, 64'd1);
    check("sim_out_pc", obs_out_pc, RPC);
    step();
    check("sim_buf_empty", {63'd0, obs_out_valid}, 64'd0);
    check("sim_req_valid", {63'd0, obs_req_valid}, 64'd1);
    check("sim_req_addr", obs_req_addr, 64'h8000_2000);

    // Redirect target alignment and address wrap.
    lat = 2;
    for (int i = 0; i < 6; i++) begin
`ifdef IFU_MISALIGN_EN
      if (tbl[i].mis) continue;
`endif
      redirect_to(tbl[i].rpc);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        step();
        got = obs_req_fire;
      end
      check("tbl_first_seen", {63'd0, got}, 64'd1);
      check("tbl_first_addr", obs_req_addr, tbl[i].first);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        step();
        got = obs_req_fire;
      end
      check("tbl_second_seen", {63'd0, got}, 64'd1);
      check("tbl_second_addr", obs_req_addr, tbl[i].second);
    end

`ifdef IFU_MISALIGN_EN
    // A misaligned redirect stalls fetch until an aligned redirect arrives.
    redirect_to(64'h8000_0006);
    for (int k = 0; k < 5; k++) begin
      step();
      check("mis_flag", {63'd0, fetch_misalign}, 64'd1);
      check("mis_req_valid", {63'd0, obs_req_valid}, 64'd0);
      check("mis_out_valid", {63'd0, obs_out_valid}, 64'd0);
    end
    redirect_to(64'h8000_0100);
    step();
    check("mis_cleared", {63'd0, fetch_misalign}, 64'd0);
    check("mis_resume_valid", {63'd0, obs_req_valid}, 64'd1);
    check("mis_resume_addr", obs_req_addr, 64'h8000_0100);
`endif

    // Reset takes priority over a simultaneous redirect.
    repeat (5) step();
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_5000;
    step();
    rst = 1'b0;
    redirect_valid = 1'b0;
    step();
    check("rst_ovr_out_valid", {63'd0, obs_out_valid}, 64'd0);
    check("rst_ovr_req_addr", obs_req_addr, RPC);
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: PC/address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32: instruction width.
REQ-003 SHALL have parameter DEPTH, default 4: prefetch entries; power of two, >=2.
REQ-004 SHALL have parameter RESET_PC, default 64'h80000000: first fetch address.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on posedge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port imem_req_valid  output  1: fetch request valid.
REQ-008 SHALL have port imem_req_ready  input  1: memory accepts request.
REQ-009 SHALL have port imem_req_addr  output  ADDR_WIDTH: fetch address, 4-byte aligned.
REQ-010 SHALL have port imem_rsp_valid  input  1: in-order response, one per accepted request, >=1 cycle after acceptance.
REQ-011 SHALL have port imem_rsp_inst  input  INST_WIDTH: response instruction.
REQ-012 SHALL have port out_valid  output  1: head instruction valid to decode.
REQ-013 SHALL have port out_ready  input  1: decode accepts head.
REQ-014 SHALL have port out_pc  output  ADDR_WIDTH: PC of head instruction.
REQ-015 SHALL have port out_inst  output  INST_WIDTH: head instruction.
REQ-016 SHALL have port redirect_valid  input  1: branch/jump/exception redirect.
REQ-017 SHALL have port redirect_pc  input  ADDR_WIDTH: new fetch PC.

Function
REQ-018 SHALL keep fetch_pc; request handshake = imem_req_valid & imem_req_ready; on handshake fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH).
REQ-019 SHALL assert imem_req_valid only in state FETCH and when buffered + outstanding < DEPTH; imem_req_addr = fetch_pc.
REQ-020 SHALL hold imem_req_addr stable while imem_req_valid & !imem_req_ready, unless redirect.
REQ-021 SHALL push {rsp_pc, imem_rsp_inst} into a circular DEPTH-entry buffer on non-dropped imem_rsp_valid; rsp_pc += 4 per push.
REQ-022 SHALL present the buffer head on out_*; pushed entry visible the next cycle (no bypass); pop on out_valid & out_ready.
REQ-023 SHALL allow simultaneous push and pop in one cycle; count unchanged; read/write pointers wrap at DEPTH.
REQ-024 SHALL track outstanding (0..DEPTH): +1 on request handshake, -1 on response, both in one cycle -> unchanged.
REQ-025 SHALL implement FSM states FETCH and FLUSH.
REQ-026 SHALL on redirect_valid (any state): clear buffer, fetch_pc <= rsp_pc <= aligned redirect_pc, drop_cnt <= outstanding minus response arriving that cycle; go FLUSH if drop_cnt nonzero else FETCH; no request issued that cycle.
REQ-027 SHALL in FLUSH discard each response and decrement drop_cnt; go FETCH when drop_cnt reaches 0; no requests issued in FLUSH.
REQ-028 SHALL complete an out handshake coinciding with redirect (instruction consumed) and then flush.
REQ-029 SHALL drop a response coinciding with redirect.
REQ-030 SHALL clear redirect_pc[1:0] when forming the new fetch PC.

Reset
REQ-031 SHALL on rst: state FETCH, fetch_pc = rsp_pc = RESET_PC, buffer empty, outstanding = drop_cnt = 0, out_valid = 0, imem_req_valid = 0.
REQ-032 SHALL issue first request (addr RESET_PC) in the first cycle after rst deasserts.
REQ-033 SHALL let rst override redirect and all handshakes; memory shares rst, so no pre-reset response arrives after reset.

Configuration
REQ-034 SHALL, with IFU_MISALIGN_EN defined, add output fetch_misalign (1 bit, reset 0), set on redirect with redirect_pc[1:0]!=0, cleared on next aligned redirect; while set imem_req_valid = 0 and out_valid = 0.
REQ-035 SHALL, without IFU_MISALIGN_EN, omit fetch_misalign and silently align per REQ-030.

Verification
REQ-036 SHALL test reset/stream: rst 1 cycle, ready=1, 1-cycle memory, out_ready=1 -> requests 0x80000000,0x80000004,...; out_pc sequence same, first out_valid 3 cycles after rst low.
REQ-037 SHALL test backpressure: out_ready=0, DEPTH=4 -> exactly 4 requests issued then imem_req_valid=0; out_ready=1 -> 4 ordered outputs, fetching resumes.
REQ-038 SHALL test redirect with 2 outstanding (3-cycle memory): redirect_pc=0x80001000 -> 2 stale responses dropped, FLUSH 2 response cycles, next out_pc=0x80001000.
REQ-039 SHALL test simultaneous redirect+response+out handshake -> head consumed, response dropped, buffer empty next cycle.
REQ-040 SHALL test redirect_pc=0x80000006 -> without macro fetch 0x80000004; with IFU_MISALIGN_EN fetch_misalign=1, no requests until redirect 0x80000100.
REQ-041 SHALL test wrap: redirect_pc=all-ones&~3 -> next request address 0.
